// File: rtl/gates7_bist_if.sv
// Signal bundle between the gate-block BIST controller and its environment.
// The slave side is the BIST; the master side drives start and the gate responses.
interface gates7_bist_if;
   logic       start;
   logic       a;
   logic       b;
   logic       f_and;
   logic       f_or;
   logic       f_not;
   logic       f_nand;
   logic       f_nor;
   logic       f_xor;
   logic       f_xnor;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [3:0] fail_vec;
   logic [6:0] fail_gates;

   modport slave (
      input  start, f_and, f_or, f_not, f_nand, f_nor, f_xor, f_xnor,
      output a, b, busy, done, pass, err_count, fail_vec, fail_gates
   );

   modport master (
      output start, f_and, f_or, f_not, f_nand, f_nor, f_xor, f_xnor,
      input  a, b, busy, done, pass, err_count, fail_vec, fail_gates
   );
endinterface

// File: rtl/gates7_bist.sv
// Built-in self test for a 7-gate block: walks the four a/b vectors, waits for
// the gates to settle, and records which vectors and which gates mismatched.
module gates7_bist #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input logic          clk,
   input logic          rst_n,
   gates7_bist_if.slave bus
);
   typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StDone} state_e;

   localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic       a_q, a_d, b_q, b_d;
   logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [2:0] err_q, err_d;
   logic [3:0] fvec_q, fvec_d;
   logic [6:0] fgates_q, fgates_d;
   logic [6:0] resp, expect_v, mism;

   assign resp = {bus.f_xnor, bus.f_xor, bus.f_nor, bus.f_nand,
                  bus.f_not, bus.f_or, bus.f_and};
   assign expect_v = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q),
                      ~a_q, a_q | b_q, a_q & b_q};

   // Case inequality so an X/Z response in simulation counts as a failure.
   always_comb begin
      mism = '0;
      for (int i = 0; i < 7; i++) begin
         mism[i] = (resp[i] !== expect_v[i]);
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      err_d    = err_q;
      fvec_d   = fvec_q;
      fgates_d = fgates_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d  = StDrive;
               idx_d    = 2'd0;
               a_d      = 1'b0;
               b_d      = 1'b0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               err_d    = 3'd0;
               fvec_d   = 4'd0;
               fgates_d = 7'd0;
            end
         end
         StDrive: begin
            state_d = StSettle;
            cnt_d   = 4'd0;
         end
         StSettle: begin
            if (cnt_q == SettleLast) begin
               state_d = StCheck;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StCheck: begin
            if (|mism) begin
               if (err_q != 3'd4) begin
                  err_d = err_q + 3'd1;
               end
               fvec_d[idx_q] = 1'b1;
               fgates_d      = fgates_q | mism;
            end
            if (idx_q == 2'd3) begin
               state_d = StDone;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == 3'd0);
            end else begin
               // Next vector goes out on this edge so a/b are stable through DRIVE.
               idx_d   = idx_q + 2'd1;
               a_d     = idx_d[0];
               b_d     = idx_d[1];
               state_d = StDrive;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         idx_q    <= 2'd0;
         cnt_q    <= 4'd0;
         a_q      <= 1'b0;
         b_q      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= 3'd0;
         fvec_q   <= 4'd0;
         fgates_q <= 7'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         fvec_q   <= fvec_d;
         fgates_q <= fgates_d;
      end
   end

   assign bus.a          = a_q;
   assign bus.b          = b_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err_count  = err_q;
   assign bus.fail_vec   = fvec_q;
   assign bus.fail_gates = fgates_q;
endmodule

// File: tb/tb_gates7_bist.sv
// Bench for gates7_bist: a fault-injectable gate block feeds two BIST instances
// (settle 1 and 15); results are compared with a per-vector reference model.
module tb_gates7_bist;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gates7_bist_if if0 ();
   gates7_bist_if if1 ();

   // Per-gate fault code: 0 good, 1 stuck-0, 2 stuck-1, 3 inverted, 4 wired to b.
   logic [6:0][2:0] code0, code1;
   logic [6:0]      g0, g1, r0, r1;
   int npass = 0;
   int ntotal = 0;

   function automatic logic [6:0] truth(input logic aa, input logic bb);
      return {~(aa ^ bb), aa ^ bb, ~(aa | bb), ~(aa & bb), ~aa, aa | bb, aa & bb};
   endfunction

   function automatic logic apply(input logic [2:0] c, input logic good, input logic bb);
      case (c)
         3'd0:    return good;
         3'd1:    return 1'b0;
         3'd2:    return 1'b1;
         3'd3:    return ~good;
         default: return bb;
      endcase
   endfunction

   always_comb begin
      g0 = truth(if0.a, if0.b);
      g1 = truth(if1.a, if1.b);
      r0 = '0;
      r1 = '0;
      for (int i = 0; i < 7; i++) begin
         r0[i] = apply(code0[i], g0[i], if0.b);
         r1[i] = apply(code1[i], g1[i], if1.b);
      end
   end

   assign {if0.f_xnor, if0.f_xor, if0.f_nor, if0.f_nand, if0.f_not, if0.f_or, if0.f_and} = r0;
   assign {if1.f_xnor, if1.f_xor, if1.f_nor, if1.f_nand, if1.f_not, if1.f_or, if1.f_and} = r1;

   gates7_bist #(.SETTLE_CYCLES(1))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   gates7_bist #(.SETTLE_CYCLES(15)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Packed view: {a, b, busy, done, pass, err_count[2:0], fail_vec[3:0], fail_gates[6:0]}
   task automatic sample(input int sel, output logic [18:0] o);
      if (sel == 0) o = {if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.err_count,
                         if0.fail_vec, if0.fail_gates};
      else          o = {if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.err_count,
                         if1.fail_vec, if1.fail_gates};
   endtask

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) if0.start = v;
      else          if1.start = v;
   endtask

   // Reference: evaluate each of the four vectors and accumulate the outcome.
   task automatic model(input logic [6:0][2:0] c, output logic [2:0] err,
                        output logic [3:0] fv, output logic [6:0] fg);
      logic [1:0] vv;
      logic [6:0] g, r, mm;
      err = 3'd0;
      fv  = 4'd0;
      fg  = 7'd0;
      for (int v = 0; v < 4; v++) begin
         vv = 2'(v);
         g  = truth(vv[0], vv[1]);
         for (int i = 0; i < 7; i++) r[i] = apply(c[i], g[i], vv[1]);
         mm = r ^ g;
         if (mm != 7'd0) begin
            err   = err + 3'd1;
            fv[v] = 1'b1;
            fg    = fg | mm;
         end
      end
   endtask

   task automatic run(input int sel, input bit hold, input string tag);
      int s, cyc, bad;
      logic [18:0] o;
      logic [2:0] e_err;
      logic [3:0] e_fv;
      logic [6:0] e_fg;
      logic [1:0] vv;
      s = (sel == 0) ? 1 : 15;
      model((sel == 0) ? code0 : code1, e_err, e_fv, e_fg);
      @(negedge clk);
      set_start(sel, 1'b1);
      @(posedge clk);
      #1;
      if (!hold) set_start(sel, 1'b0);
      sample(sel, o);
      check({tag, ".cleared"}, 32'(o[16:0]), 32'h10000);
      cyc = 0;
      bad = 0;
      while (o[16] === 1'b1 && cyc < 300) begin
         vv = 2'(cyc / (s + 2));
         if (o[18] !== vv[0] || o[17] !== vv[1] || o[15] !== 1'b0 || o[14] !== 1'b0) bad++;
         cyc++;
         @(posedge clk);
         #1;
         sample(sel, o);
      end
      if (hold) set_start(sel, 1'b0);
      check({tag, ".busy_cycles"}, 32'(cyc), 32'(4 * (s + 2)));
      check({tag, ".ab_seq"}, 32'(bad), 32'd0);
      check({tag, ".done"}, 32'(o[15]), 32'd1);
      check({tag, ".pass"}, 32'(o[14]), 32'(e_err == 3'd0));
      check({tag, ".err_count"}, 32'(o[13:11]), 32'(e_err));
      check({tag, ".fail_vec"}, 32'(o[10:7]), 32'(e_fv));
      check({tag, ".fail_gates"}, 32'(o[6:0]), 32'(e_fg));
      check({tag, ".ab_final"}, 32'(o[18:17]), 32'd1 << 1 | 32'd1);
      repeat (3) @(posedge clk);
      #1;
      sample(sel, o);
      check({tag, ".hold"}, 32'(o[16:0]),
            32'({1'b0, 1'b1, (e_err == 3'd0), e_err, e_fv, e_fg}));
   endtask

   initial begin
      logic [18:0] o;
      code0 = '0;
      code1 = '0;
      if0.start = 1'b0;
      if1.start = 1'b0;
      #12;
      sample(0, o);
      check("reset.dut0", 32'(o), 32'd0);
      sample(1, o);
      check("reset.dut1", 32'(o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      sample(0, o);
      check("idle_wait", 32'(o), 32'd0);

      run(0, 1'b0, "good");
      code0[5] = 3'd1;
      run(0, 1'b0, "xor_stuck0");
      code0 = '0;
      code0[2] = 3'd4;
      run(0, 1'b0, "not_to_b");
      code0 = '0;
      code0[5] = 3'd1;
      run(0, 1'b1, "start_held");
      code0 = '0;
      run(0, 1'b0, "restart");

      // Abort during the SETTLE of vector 2.
      @(negedge clk);
      if0.start = 1'b1;
      @(posedge clk);
      #1;
      if0.start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      sample(0, o);
      check("abort.pre", 32'(o[18:16]), 32'b011);
      #2;
      rst_n = 1'b0;
      #1;
      sample(0, o);
      check("abort.async", 32'(o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      sample(0, o);
      check("abort.idle", 32'(o), 32'd0);
      run(0, 1'b0, "after_abort");

      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 7; i++) code0[i] = 3'($urandom_range(4, 0));
         run(0, 1'b0, $sformatf("rand%0d", k));
      end

      run(1, 1'b0, "settle15");
      for (int i = 0; i < 7; i++) code1[i] = 3'($urandom_range(4, 0));
      run(1, 1'b0, "settle15_rand");

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
